// File: rtl/shdw_pkg.sv
// rtl/shdw_pkg.sv - shared types and defaults for the shadow-chain dump sequencer (option macro: SHDW_PARITY_EN)
package shdw_pkg;

    localparam int DEF_LANES = 32;
    localparam int DEF_DEPTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_DONE   = 2'd2
    } shdw_state_e;

    // Bits emitted per dump: the captured bits, plus a trailing even-parity bit when enabled.
    function automatic int shdw_len(input int depth);
`ifdef SHDW_PARITY_EN
        return depth + 1;
`else
        return depth;
`endif
    endfunction

endpackage

// File: rtl/shdw_lane.sv
// rtl/shdw_lane.sv - one shadow chain: capture a snapshot, then shift it out LSB first on request (option macro: SHDW_PARITY_EN)
module shdw_lane
    import shdw_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sh_rst,
    input  logic             capture,
    input  logic             dump_en,
    input  logic [DEPTH-1:0] snap,
    output logic             sh_out,
    output logic             sh_out_vld,
    output logic             sh_out_done
);

    localparam int LEN = shdw_len(DEPTH);
    localparam int CW  = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    shdw_state_e    state_q, state_d;
    logic [LEN-1:0] shreg_q, shreg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sh_out_q, sh_out_d;
    logic           vld_q, vld_d;
    logic [LEN-1:0] load_val;

    // The parity bit sits above the data so it naturally leaves the chain last.
`ifdef SHDW_PARITY_EN
    assign load_val = {^snap, snap};
`else
    assign load_val = snap;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sh_rst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (capture) state_d = ST_LOADED;
                end
                ST_LOADED: begin
                    if (dump_en && cnt_q == LAST) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        sh_out_d = sh_out_q;
        vld_d    = 1'b0;
        if (sh_rst) begin
            shreg_d  = '0;
            cnt_d    = '0;
            sh_out_d = 1'b0;
        end else if (state_q == ST_LOADED) begin
            if (dump_en) begin
                sh_out_d = shreg_q[0];
                vld_d    = 1'b1;
                shreg_d  = shreg_q >> 1;
                cnt_d    = cnt_q + CW'(1);
            end
        end else begin
            // Capture wins over a same-cycle dump_en; shifting starts next cycle at the earliest.
            sh_out_d = 1'b0;
            if (capture) begin
                shreg_d = load_val;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            sh_out_q <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            sh_out_q <= sh_out_d;
            vld_q    <= vld_d;
        end
    end

    assign sh_out      = sh_out_q;
    assign sh_out_vld  = vld_q;
    assign sh_out_done = (state_q != ST_LOADED);

endmodule

// File: rtl/shdw_dump_seq.sv
// rtl/shdw_dump_seq.sv - multi-lane shadow dump sequencer: capture edge detect and per-lane fan-out (option macro: SHDW_PARITY_EN)
module shdw_dump_seq
    import shdw_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sh_rst,
    input  logic                   c_en,
    input  logic [LANES-1:0]       dump_en,
    input  logic [LANES*DEPTH-1:0] snap_in,
    output logic [LANES-1:0]       sh_out,
    output logic [LANES-1:0]       sh_out_vld,
    output logic [LANES-1:0]       sh_out_done
);

    logic c_en_q, c_en_d;
    logic capture;

    always_comb begin
        c_en_d = c_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_en_q <= 1'b0;
        end else begin
            c_en_q <= c_en_d;
        end
    end

    // A single shared rising-edge pulse keeps all lanes capturing in the same cycle.
    assign capture = c_en & ~c_en_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        shdw_lane #(
            .DEPTH(DEPTH)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .sh_rst      (sh_rst),
            .capture     (capture),
            .dump_en     (dump_en[g]),
            .snap        (snap_in[g*DEPTH +: DEPTH]),
            .sh_out      (sh_out[g]),
            .sh_out_vld  (sh_out_vld[g]),
            .sh_out_done (sh_out_done[g])
        );
    end

endmodule

// File: tb/tb_shdw_dump_seq.sv
// tb/tb_shdw_dump_seq.sv - scoreboard bench for shdw_dump_seq with two 4-bit lanes (option macro: SHDW_PARITY_EN)
module tb_shdw_dump_seq;

    localparam int LANES = 2;
    localparam int DEPTH = 4;
`ifdef SHDW_PARITY_EN
    localparam int LEN = 5;
`else
    localparam int LEN = 4;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   sh_rst;
    logic                   c_en;
    logic [LANES-1:0]       dump_en;
    logic [LANES*DEPTH-1:0] snap_in;
    logic [LANES-1:0]       sh_out;
    logic [LANES-1:0]       sh_out_vld;
    logic [LANES-1:0]       sh_out_done;

    int n_cmp = 0;
    int n_err = 0;
    int vld_cnt [LANES];

    // Each entry: {is_last_bit, bit_value}
    logic [1:0] q0 [$];
    logic [1:0] q1 [$];
    logic [1:0] mon_e;
    logic       mon_have;

    shdw_dump_seq #(
        .LANES(LANES),
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sh_rst      (sh_rst),
        .c_en        (c_en),
        .dump_en     (dump_en),
        .snap_in     (snap_in),
        .sh_out      (sh_out),
        .sh_out_vld  (sh_out_vld),
        .sh_out_done (sh_out_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_stream(input int lane, input logic [3:0] bits, input logic par);
        logic [1:0] item;
        for (int b = 0; b < LEN; b++) begin
            item[0] = (b < DEPTH) ? bits[b] : par;
            item[1] = (b == LEN - 1);
            if (lane == 0) q0.push_back(item);
            else           q1.push_back(item);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < LANES; i++) vld_cnt[i] = 0;
    endtask

    task automatic chk_drained(input string nm);
        chk({nm, "_q0_empty"}, q0.size(), 0);
        chk({nm, "_q1_empty"}, q1.size(), 0);
        chk({nm, "_cnt0"}, vld_cnt[0], LEN);
        chk({nm, "_cnt1"}, vld_cnt[1], LEN);
        chk({nm, "_done"}, sh_out_done, 2'b11);
        chk({nm, "_vld_idle"}, sh_out_vld, 2'b00);
        chk({nm, "_out_idle"}, sh_out, 2'b00);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                if (sh_out_vld[i]) begin
                    vld_cnt[i]++;
                    mon_have = 1'b0;
                    if (i == 0 && q0.size() > 0) begin
                        mon_e = q0.pop_front();
                        mon_have = 1'b1;
                    end else if (i == 1 && q1.size() > 0) begin
                        mon_e = q1.pop_front();
                        mon_have = 1'b1;
                    end
                    if (!mon_have) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_vld lane %0d: got vld=1 expected no pending bit", i);
                    end else begin
                        chk($sformatf("bit_l%0d", i), sh_out[i], mon_e[0]);
                        chk($sformatf("done_with_bit_l%0d", i), sh_out_done[i], mon_e[1]);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; sh_rst = 1'b0; c_en = 1'b0; dump_en = '0;
        snap_in = {4'b0110, 4'b1011};
        clr_cnt();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_vld", sh_out_vld, 2'b00);
        chk("rst_out", sh_out, 2'b00);
        chk("rst_done", sh_out_done, 2'b11);
        rst = 1'b0;
        step();

        // Full dump, both lanes in lockstep
        c_en = 1'b1;
        push_stream(0, 4'b1011, 1'b1);
        push_stream(1, 4'b0110, 1'b0);
        step();
        chk("full_done_fall", sh_out_done, 2'b00);
        chk("full_no_vld_yet", sh_out_vld, 2'b00);
        dump_en = 2'b11;
        for (int k = 0; k < LEN; k++) begin
            step();
            chk("full_vld", sh_out_vld, 2'b11);
        end
        dump_en = 2'b00;
        c_en = 1'b0;
        step();
        chk_drained("full");

        // Stalled dump: vld tracks dump_en one cycle later
        c_en = 1'b1;
        push_stream(0, 4'b1011, 1'b1);
        push_stream(1, 4'b0110, 1'b0);
        step();
        c_en = 1'b0;
        clr_cnt();
        for (int k = 0; k < 2 * LEN; k++) begin
            dump_en = (k % 2 == 0) ? 2'b11 : 2'b00;
            step();
            chk("stall_vld", sh_out_vld, dump_en);
        end
        dump_en = 2'b00;
        step();
        chk_drained("stall");

        // Capture edge during a dump is ignored
        c_en = 1'b1;
        push_stream(0, 4'b1011, 1'b1);
        push_stream(1, 4'b0110, 1'b0);
        step();
        c_en = 1'b0;
        clr_cnt();
        dump_en = 2'b11;
        step();
        step();
        snap_in = {4'b1111, 4'b0000};
        c_en = 1'b1;
        step();
        chk("ignored_cap_done", sh_out_done, 2'b00);
        for (int k = 0; k < LEN - 3; k++) step();
        dump_en = 2'b00;
        c_en = 1'b0;
        step();
        chk_drained("ignored_cap");

        // Reload after done; same-cycle dump_en loses to capture
        snap_in = {4'b1001, 4'b0100};
        c_en = 1'b1;
        dump_en = 2'b11;
        push_stream(0, 4'b0100, 1'b1);
        push_stream(1, 4'b1001, 1'b0);
        clr_cnt();
        step();
        chk("cap_priority_vld", sh_out_vld, 2'b00);
        chk("cap_priority_done", sh_out_done, 2'b00);
        c_en = 1'b0;
        for (int k = 0; k < LEN; k++) step();
        dump_en = 2'b00;
        step();
        chk_drained("reload");

        // Asynchronous reset mid-dump
        snap_in = {4'b0110, 4'b1011};
        c_en = 1'b1;
        push_stream(0, 4'b1011, 1'b1);
        push_stream(1, 4'b0110, 1'b0);
        step();
        c_en = 1'b0;
        dump_en = 2'b11;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_vld", sh_out_vld, 2'b00);
        chk("rst_mid_done", sh_out_done, 2'b11);
        chk("rst_mid_out", sh_out, 2'b00);
        q0.delete();
        q1.delete();
        step();
        rst = 1'b0;
        clr_cnt();
        for (int k = 0; k < LEN + 1; k++) begin
            step();
            chk("post_rst_done", sh_out_done, 2'b11);
        end
        chk("post_rst_cnt0", vld_cnt[0], 0);
        chk("post_rst_cnt1", vld_cnt[1], 0);

        // sh_rst coincident with a capture edge
        dump_en = 2'b00;
        c_en = 1'b0;
        step();
        sh_rst = 1'b1;
        c_en = 1'b1;
        step();
        chk("shrst_done", sh_out_done, 2'b11);
        chk("shrst_out", sh_out, 2'b00);
        sh_rst = 1'b0;
        dump_en = 2'b11;
        clr_cnt();
        for (int k = 0; k < LEN + 1; k++) begin
            step();
            chk("shrst_no_vld", sh_out_vld, 2'b00);
        end
        chk("shrst_cnt0", vld_cnt[0], 0);
        chk("shrst_cnt1", vld_cnt[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shdw_dump_seq.md
SHDW_DUMP_SEQ -- requirements
Module: shdw_dump_seq

Interface
REQ-001 SHALL have parameter LANES, default 32, number of independent shadow chains.
REQ-002 SHALL have parameter DEPTH, default 64, captured bits per lane, legal range 2..1024.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on posedge clk.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port sh_rst, input, 1, synchronous shadow clear, level.
REQ-006 SHALL have port c_en, input, 1, capture enable, level; a 0->1 transition triggers capture.
REQ-007 SHALL have port dump_en, input, LANES, per-lane shift-out request for this cycle.
REQ-008 SHALL have port snap_in, input, LANES*DEPTH, core state to capture; lane i occupies bits [i*DEPTH +: DEPTH].
REQ-009 SHALL have port sh_out, output, LANES, registered serial data bit per lane.
REQ-010 SHALL have port sh_out_vld, output, LANES, per-lane flag marking sh_out[i] valid this cycle.
REQ-011 SHALL have port sh_out_done, output, LANES, per-lane flag: high when no dump is pending.

Function
REQ-012 SHALL run a per-lane FSM with states IDLE, LOADED, DONE.
REQ-013 SHALL edge-detect c_en with a registered copy c_en_q; capture = c_en & ~c_en_q.
REQ-014 SHALL, on capture in IDLE or DONE: load snap_in lane i into shreg[i], clear cnt[i], and go to LOADED.
REQ-015 SHALL ignore capture while in LOADED; the dump in progress continues unaffected.
REQ-016 SHALL, in LOADED with dump_en[i]=1, perform one shift per cycle:
- sh_out[i] <= shreg[i][0] (LSB first);
- sh_out_vld[i] <= 1;
- shreg[i] shifts right by 1;
- cnt[i] increments.
REQ-017 SHALL, in LOADED with dump_en[i]=0, set sh_out_vld[i] <= 0 and hold sh_out[i], shreg[i] and cnt[i].
REQ-018 SHALL go from LOADED to DONE in the cycle that emits the last bit (cnt = LEN-1), where LEN = DEPTH, or DEPTH+1 with parity enabled.
REQ-019 SHALL drive sh_out_done[i]=1 in IDLE and DONE and 0 in LOADED.
- sh_out_done falls the cycle after capture.
- sh_out_done rises together with the sh_out_vld pulse that carries the last bit.
REQ-020 SHALL keep sh_out_vld[i]=0 and sh_out[i]=0 whenever the lane is in IDLE or DONE, regardless of dump_en.
REQ-021 SHALL give capture priority over dump_en when both occur in the same cycle in IDLE/DONE; the first shift happens the next cycle at the earliest.
REQ-022 SHALL have a latency of exactly 1 clock from dump_en[i] to the matching sh_out_vld[i].
REQ-023 SHALL size cnt as clog2(LEN+1) bits; cnt never wraps, because the transition to DONE stops counting.
REQ-024 SHALL let lanes progress independently; with identical dump_en on all lanes, all lanes stay in lockstep.
REQ-025 SHALL, on sh_rst=1, return every lane to IDLE next clock, clear shreg/cnt/sh_out/sh_out_vld and set sh_out_done; sh_rst has priority over capture and shift.

Reset
REQ-026 SHALL, on rst=1, asynchronously force:
- state=IDLE, shreg=0, cnt=0, c_en_q=0;
- sh_out=0, sh_out_vld=0, sh_out_done=all ones.
REQ-027 SHALL abort any dump in progress on rst; no further sh_out_vld occurs until a new capture.

Configuration
REQ-028 SHALL, with SHDW_PARITY_EN defined, append one even-parity bit (XOR of the DEPTH captured bits, computed at capture) after the last data bit; LEN = DEPTH+1.
REQ-029 SHALL, without SHDW_PARITY_EN, emit exactly DEPTH bits per lane with no parity logic.

Structure
REQ-030 SHALL place the state-encoding typedef (IDLE/LOADED/DONE) and the default LANES/DEPTH constants in package shdw_pkg.
REQ-031 SHALL implement one lane as sub-module shdw_lane, instantiated LANES times by generate; edge detect and sh_rst fan-out live in the top level.

Verification
REQ-032 SHALL check a full dump:
- stimulus: DEPTH=4, lane0 snap=4'b1011, c_en 0->1, then dump_en=all ones for 4 cycles;
- response: lane0 sh_out=1,1,0,1 with vld=1 each cycle, done=0 until the 4th bit, done=1 with the 4th vld.
REQ-033 SHALL check stalled dump: dump_en toggling 1,0,1,0... -> vld follows dump_en delayed 1 cycle; bit order unchanged; done after exactly 4 vld pulses.
REQ-034 SHALL check capture during dump: second c_en rising edge after 2 bits -> ignored, remaining 2 original bits emitted; next capture after done reloads the lane.
REQ-035 SHALL check rst mid-dump: rst asserted after 2 bits -> immediately sh_out_vld=0, sh_out_done=all ones; dump_en afterwards yields no vld.
REQ-036 SHALL check sh_rst together with a capture edge in the same cycle -> lane stays IDLE, done=1, no vld on later dump_en.
REQ-037 SHALL check SHDW_PARITY_EN:
- stimulus: snap=4'b1011 (parity 1);
- response: 5 vld pulses, last bit 1; without the macro only 4 pulses.
